// File: rtl/nvme_pkg.sv
// Shared constants for the NVMe command path: scheduler state codes, admin opcodes, CID width.
package nvme_pkg;

  localparam int CID_W = 16;
  localparam int OPC_W = 8;

  localparam logic [2:0] SCH_IDLE  = 3'd0;
  localparam logic [2:0] SCH_ARB   = 3'd1;
  localparam logic [2:0] SCH_ISSUE = 3'd2;
  localparam logic [2:0] SCH_WAIT  = 3'd3;
  localparam logic [2:0] SCH_DONE  = 3'd4;
  localparam logic [2:0] SCH_ERR   = 3'd5;

  localparam logic [OPC_W-1:0] OPC_DELETE_IOSQ  = 8'h00;
  localparam logic [OPC_W-1:0] OPC_CREATE_IOSQ  = 8'h01;
  localparam logic [OPC_W-1:0] OPC_GET_LOG_PAGE = 8'h02;
  localparam logic [OPC_W-1:0] OPC_DELETE_IOCQ  = 8'h04;
  localparam logic [OPC_W-1:0] OPC_CREATE_IOCQ  = 8'h05;
  localparam logic [OPC_W-1:0] OPC_IDENTIFY     = 8'h06;
  localparam logic [OPC_W-1:0] OPC_ABORT        = 8'h08;
  localparam logic [OPC_W-1:0] OPC_SET_FEATURES = 8'h09;
  localparam logic [OPC_W-1:0] OPC_GET_FEATURES = 8'h0A;

  // Requester index successor with wrap at n-1; indices never exceed 3 bits.
  function automatic logic [3:0] wrap_inc(input logic [3:0] idx, input int unsigned n);
    return (idx == 4'(n - 1)) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/nvme_cmd_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!any_o && req_i[cand[IW-1:0]]) begin
        any_o             = 1'b1;
        idx_o             = cand[IW-1:0];
        gnt_o[cand[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nvme_cmd_sched.sv
// Round-robin command scheduler sharing the tx_cc encoder among NUM_REQ requesters,
// with CID assignment, send_cmd/send_cmd_done handshake and a timeout watchdog.
module nvme_cmd_sched
  import nvme_pkg::*;
#(
  parameter int                NUM_REQ     = 4,
  parameter int                TIMEOUT_CYC = 4096,
  parameter logic [CID_W-1:0]  CID_INIT    = 16'h0
) (
  input  logic                   user_clk,
  input  logic                   user_reset_n,
  input  logic                   user_lnk_up,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_opcode,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic [OPC_W-1:0]       cmd_opcode,
  output logic [CID_W-1:0]       cmd_cid,
  output logic                   send_cmd,
  input  logic [3:0]             cc_tready,
  input  logic                   send_cmd_done,
  output logic                   busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic [2:0]           state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        win_q, win_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 send_q, send_d;
  logic                 busy_q, busy_d;
  logic [OPC_W-1:0]     opc_q, opc_d;
  logic [CID_W-1:0]     cid_q, cid_d;
  logic                 sdone_prev_q;
  logic                 sdone_rise;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [OPC_W-1:0]     opc_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_opc
    assign opc_arr[gi] = req_opcode[OPC_W*gi +: OPC_W];
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // A level already high when WAIT is entered must not count as completion.
  assign sdone_rise = send_cmd_done & ~sdone_prev_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    timer_d = timer_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = '0;
    send_d  = send_q;
    opc_d   = opc_q;
    cid_d   = cid_q;
    case (state_q)
      SCH_IDLE: begin
        if (|req) state_d = SCH_ARB;
      end
      SCH_ARB: begin
        if (arb_any) begin
          grant_d = arb_gnt;
          win_d   = arb_idx;
          opc_d   = opc_arr[arb_idx];
          send_d  = 1'b1;
          state_d = SCH_ISSUE;
        end else begin
          state_d = SCH_IDLE;
        end
      end
      SCH_ISSUE: begin
        if (|cc_tready && send_q) begin
          send_d  = 1'b0;
          timer_d = '0;
          state_d = SCH_WAIT;
        end
      end
      SCH_WAIT: begin
        if (timer_q != {TW{1'b1}}) timer_d = timer_q + 1'b1;
        if (sdone_rise) begin
          done_d  = grant_q;
          state_d = SCH_DONE;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = grant_q;
          state_d = SCH_ERR;
        end
      end
      SCH_DONE: begin
        grant_d = '0;
        cid_d   = cid_q + 1'b1;
        ptr_d   = IW'(wrap_inc(4'(win_q), NUM_REQ));
        state_d = SCH_IDLE;
      end
      SCH_ERR: begin
        grant_d = '0;
        ptr_d   = IW'(wrap_inc(4'(win_q), NUM_REQ));
        state_d = SCH_IDLE;
      end
      default: begin
        grant_d = '0;
        send_d  = 1'b0;
        state_d = SCH_IDLE;
      end
    endcase
    busy_d = (state_d != SCH_IDLE);
  end

  // Link-down is treated exactly like reset; an in-flight command is dropped silently.
  always_ff @(posedge user_clk) begin
    if (!user_reset_n || !user_lnk_up) begin
      state_q      <= SCH_IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      timer_q      <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      err_q        <= '0;
      send_q       <= 1'b0;
      busy_q       <= 1'b0;
      opc_q        <= '0;
      cid_q        <= CID_INIT;
      sdone_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      timer_q      <= timer_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      err_q        <= err_d;
      send_q       <= send_d;
      busy_q       <= busy_d;
      opc_q        <= opc_d;
      cid_q        <= cid_d;
      sdone_prev_q <= send_cmd_done;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign err        = err_q;
  assign send_cmd   = send_q;
  assign busy       = busy_q;
  assign cmd_opcode = opc_q;
  assign cmd_cid    = cid_q;

endmodule

// File: tb/tb_nvme_cmd_sched.sv
// Self-checking bench for nvme_cmd_sched: directed vector table, hand sequences, randomized commands.
`timescale 1ns/1ps
module tb_nvme_cmd_sched;
  import nvme_pkg::*;

  localparam int NREQ = 4;
  localparam int TOUT = 16;

  logic        user_clk = 1'b0;
  logic        user_reset_n = 1'b0;
  logic        user_lnk_up = 1'b1;
  logic [3:0]  req = 4'h0;
  logic [31:0] req_opcode = 32'h0;
  logic [3:0]  cc_tready = 4'h0;
  logic        send_cmd_done = 1'b0;

  logic [3:0]  grant, done, err, grant_w, done_w, err_w;
  logic [7:0]  cmd_opcode, cmd_opcode_w;
  logic [15:0] cmd_cid, cmd_cid_w;
  logic        send_cmd, send_cmd_w, busy, busy_w;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] m_cid;
  int          m_ptr;

  typedef struct {
    logic [3:0] rq;
    int         stall;
    logic [3:0] trdy;
    int         dly;
    bit         stale;
    bit         drop;
    int         exp_w;
    bit         exp_done;
  } vec_t;

  vec_t tbl [16];

  always #5 user_clk = ~user_clk;

  nvme_cmd_sched #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TOUT), .CID_INIT(16'h0000)) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n), .user_lnk_up(user_lnk_up),
    .req(req), .req_opcode(req_opcode), .grant(grant), .done(done), .err(err),
    .cmd_opcode(cmd_opcode), .cmd_cid(cmd_cid), .send_cmd(send_cmd),
    .cc_tready(cc_tready), .send_cmd_done(send_cmd_done), .busy(busy)
  );

  // Second instance preloaded with FFFF to observe CID wrap on identical stimulus.
  nvme_cmd_sched #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TOUT), .CID_INIT(16'hFFFF)) dut_w (
    .user_clk(user_clk), .user_reset_n(user_reset_n), .user_lnk_up(user_lnk_up),
    .req(req), .req_opcode(req_opcode), .grant(grant_w), .done(done_w), .err(err_w),
    .cmd_opcode(cmd_opcode_w), .cmd_cid(cmd_cid_w), .send_cmd(send_cmd_w),
    .cc_tready(cc_tready), .send_cmd_done(send_cmd_done), .busy(busy_w)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference arbitration: scan requesters starting at the rotation pointer.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // One full command, entered at a negedge with the DUT idle; leaves at the idle negedge after the pulse.
  task automatic do_cmd(input logic [3:0] rq, input int stall, input logic [3:0] trdy, input int dly,
                        input bit stale, input bit drop, input int exp_w, input bit exp_done);
    int lat, sc, pc, exp_pc;
    logic [3:0] oh;
    logic [7:0] exp_opc;
    oh      = 4'(1 << exp_w);
    exp_opc = req_opcode[8*exp_w +: 8];
    req = rq;
    cc_tready = (stall > 0) ? 4'h0 : trdy;
    send_cmd_done = stale;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge user_clk);
      if (grant != 4'h0) begin lat = c; break; end
    end
    chk("grant_latency", lat, 2);
    if (lat == 0) return;
    chk("grant", grant, oh);
    chk("grant_w", grant_w, oh);
    chk("cmd_opcode", cmd_opcode, exp_opc);
    chk("cmd_opcode_w", cmd_opcode_w, exp_opc);
    chk("cmd_cid", cmd_cid, m_cid);
    chk("cmd_cid_w", cmd_cid_w, 16'(m_cid + 16'hFFFF));
    chk("send_cmd_issue", {send_cmd, send_cmd_w}, 2'b11);
    chk("busy", {busy, busy_w}, 2'b11);
    sc = 1;
    for (int k = 0; k < stall; k++) begin
      @(negedge user_clk);
      if (send_cmd) sc++;
    end
    cc_tready = trdy;
    @(negedge user_clk);
    chk("send_cmd_cycles", sc, stall + 1);
    chk("send_cmd_accept", {send_cmd, send_cmd_w}, 0);
    send_cmd_done = 1'b0;
    if (drop) req[exp_w] = 1'b0;
    exp_pc = (dly <= TOUT - 1) ? dly + 1 : TOUT;
    pc = 0;
    for (int c = 0; c < TOUT + 4; c++) begin
      if (c == dly) send_cmd_done = 1'b1;
      @(negedge user_clk);
      if ((done | err) != 4'h0) begin pc = c + 1; break; end
    end
    chk("pulse_cycle", pc, exp_pc);
    chk("done", done, exp_done ? oh : 4'h0);
    chk("err", err, exp_done ? 4'h0 : oh);
    chk("done_w", done_w, exp_done ? oh : 4'h0);
    chk("err_w", err_w, exp_done ? 4'h0 : oh);
    chk("grant_at_pulse", grant, oh);
    if (exp_done) m_cid++;
    m_ptr = (exp_w + 1) % NREQ;
    send_cmd_done = 1'b0;
    @(negedge user_clk);
    chk("pulse_width", {done, err, done_w, err_w}, 0);
    chk("grant_release", grant, 0);
    chk("busy_idle", busy, 0);
    chk("cid_next", cmd_cid, m_cid);
    chk("cid_next_w", cmd_cid_w, 16'(m_cid + 16'hFFFF));
    $display("[TB] cmd req=%b w=%0d opc=%02h result=%s pulse@%0d next_cid=%04h",
             rq, exp_w, exp_opc, exp_done ? "done" : "timeout", pc, m_cid);
  endtask

  initial begin
    logic [3:0] rq, tr;
    int st, dl, w, cnt;
    bit stl, drp;

    //           req    stall trdy   dly stale drop w  done
    tbl[0]  = '{4'hF,   0,    4'hF,  3,  0,    0,   0, 1};
    tbl[1]  = '{4'hF,   0,    4'hF,  5,  0,    0,   1, 1};
    tbl[2]  = '{4'hF,   2,    4'hF,  0,  0,    0,   2, 1};
    tbl[3]  = '{4'hF,   0,    4'h1,  7,  0,    0,   3, 1};
    tbl[4]  = '{4'hF,   0,    4'hF,  1,  0,    0,   0, 1};
    tbl[5]  = '{4'hF,   0,    4'hF,  2,  0,    0,   1, 1};
    tbl[6]  = '{4'hF,   0,    4'hF,  4,  0,    0,   2, 1};
    tbl[7]  = '{4'hF,   0,    4'hF,  6,  0,    0,   3, 1};
    tbl[8]  = '{4'b0100, 0,   4'hF,  6,  0,    0,   2, 1};
    tbl[9]  = '{4'b1010, 20,  4'hF,  2,  0,    0,   3, 1};
    tbl[10] = '{4'b0011, 0,   4'hF,  20, 0,    0,   0, 0};
    tbl[11] = '{4'b0011, 0,   4'hF,  2,  0,    0,   1, 1};
    tbl[12] = '{4'b0110, 0,   4'hF,  4,  1,    0,   2, 1};
    tbl[13] = '{4'b1001, 0,   4'hF,  15, 0,    1,   3, 1};
    tbl[14] = '{4'b0001, 3,   4'h8,  16, 0,    0,   0, 0};
    tbl[15] = '{4'hF,   0,    4'h2,  0,  0,    0,   1, 1};

    // Reset held with all requests pending.
    req_opcode = {OPC_GET_LOG_PAGE, OPC_IDENTIFY, OPC_CREATE_IOCQ, OPC_CREATE_IOSQ};
    req = 4'hF;
    cc_tready = 4'hF;
    repeat (4) @(negedge user_clk);
    chk("rst_grant", {grant, grant_w}, 0);
    chk("rst_pulses", {done, err, done_w, err_w}, 0);
    chk("rst_send_busy", {send_cmd, busy, send_cmd_w, busy_w}, 0);
    chk("rst_opcode", cmd_opcode, 0);
    chk("rst_cid", cmd_cid, 16'h0000);
    chk("rst_cid_w", cmd_cid_w, 16'hFFFF);
    m_cid = 16'h0;
    m_ptr = 0;
    user_reset_n = 1'b1;

    for (int i = 0; i < 16; i++)
      do_cmd(tbl[i].rq, tbl[i].stall, tbl[i].trdy, tbl[i].dly, tbl[i].stale, tbl[i].drop,
             tbl[i].exp_w, tbl[i].exp_done);

    // Request vanishes before arbitration: no grant, back to idle.
    req = 4'b0001;
    @(negedge user_clk);
    req = 4'b0000;
    chk("arb_abort_busy", busy, 1);
    cnt = 0;
    repeat (4) begin
      @(negedge user_clk);
      if (grant != 4'h0 || send_cmd) cnt++;
    end
    chk("arb_abort_no_grant", cnt, 0);
    chk("arb_abort_idle", busy, 0);
    $display("[TB] arb-abort sequence stray_cycles=%0d", cnt);

    // Link drop while waiting for completion.
    req = 4'b0010;
    cc_tready = 4'hF;
    send_cmd_done = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge user_clk);
      if (grant != 4'h0) begin cnt = c; break; end
    end
    chk("ld_grant", grant, 4'b0010);
    repeat (3) @(negedge user_clk);
    chk("ld_busy_wait", busy, 1);
    user_lnk_up = 1'b0;
    @(negedge user_clk);
    chk("ld_grant_clr", {grant, grant_w}, 0);
    chk("ld_busy", {busy, busy_w, send_cmd}, 0);
    chk("ld_pulse", {done, err}, 0);
    chk("ld_cid", cmd_cid, 16'h0000);
    chk("ld_cid_w", cmd_cid_w, 16'hFFFF);
    chk("ld_opcode", cmd_opcode, 0);
    user_lnk_up = 1'b1;
    req = 4'h0;
    send_cmd_done = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge user_clk);
      if ((done | err | done_w | err_w) != 4'h0) cnt++;
    end
    chk("ld_no_pulse", cnt, 0);
    send_cmd_done = 1'b0;
    $display("[TB] link-drop sequence stray_pulses=%0d", cnt);
    m_cid = 16'h0;
    m_ptr = 0;
    @(negedge user_clk);

    // Pointer restarted at 0, so requester 1 beats 3; dut_w wraps FFFF -> 0000 here.
    do_cmd(4'b1010, 0, 4'hF, 2, 0, 0, 1, 1);

    for (int n = 0; n < 40; n++) begin
      rq  = 4'($urandom_range(1, 15));
      tr  = 4'($urandom_range(1, 15));
      st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      dl  = int'($urandom_range(0, 20));
      stl = ($urandom_range(0, 3) == 0);
      drp = ($urandom_range(0, 3) == 0);
      if (stl && dl == 0) dl = 1;
      req_opcode = $urandom;
      w = pick(rq, m_ptr);
      do_cmd(rq, st, tr, dl, stl, drp, w, dl <= TOUT - 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

endmodule
